// File: rtl/keypad_entry.sv
// keypad_entry: scans a 4x4 active-low keypad, debounces and decodes keys, builds an operand and add/sub mode
module keypad_entry #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic [7:0] operand,
    output logic       op_valid,
    output logic       add,
    output logic       sub
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} state_t;

    state_t        state, state_n;
    logic [3:0]    r1, rs, col_n, code;
    logic [SW-1:0] slot;
    logic [DW-1:0] db, db_n, db_inc;
    logic [1:0]    ridx, cidx, ridx_n, cidx_n, win, cur;
    logic          sample, idle, fire;

    assign sample = slot == SW'(SCAN_DIV - 1);
    assign idle   = rs == 4'hF;
    assign win    = !rs[0] ? 2'd0 : !rs[1] ? 2'd1 : !rs[2] ? 2'd2 : 2'd3;
    assign cur    = !col[0] ? 2'd0 : !col[1] ? 2'd1 : !col[2] ? 2'd2 : 2'd3;
    assign db_inc = db + DW'(1);
    assign code   = {ridx, cidx};

    // two-stage row synchroniser and the free-running column slot timer
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            r1   <= 4'hF;
            rs   <= 4'hF;
            slot <= '0;
        end else begin
            r1   <= row;
            rs   <= r1;
            slot <= sample ? '0 : slot + SW'(1);
        end

    // scan/debounce state, column drive and captured key position
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            state <= SCAN;
            col   <= 4'b1110;
            db    <= '0;
            ridx  <= '0;
            cidx  <= '0;
        end else begin
            state <= state_n;
            col   <= col_n;
            db    <= db_n;
            ridx  <= ridx_n;
            cidx  <= cidx_n;
        end

    // next-state logic; every decision is taken only at a slot sample point
    always_comb begin
        state_n = state;
        col_n   = col;
        db_n    = db;
        ridx_n  = ridx;
        cidx_n  = cidx;
        fire    = 1'b0;
        if (sample)
            case (state)
                SCAN:
                    if (idle) col_n = {col[2:0], col[3]};
                    else begin
                        ridx_n  = win;
                        cidx_n  = cur;
                        db_n    = '0;
                        state_n = PRESS_DB;
                    end
                PRESS_DB:
                    if (rs[ridx]) state_n = SCAN;
                    else begin
                        db_n = db_inc;
                        if (db_inc == DW'(DEBOUNCE)) begin
                            fire    = 1'b1;
                            state_n = HELD;
                        end
                    end
                HELD:
                    if (idle) begin
                        db_n    = '0;
                        state_n = REL_DB;
                    end
                REL_DB:
                    if (!idle) state_n = HELD;
                    else begin
                        db_n = db_inc;
                        if (db_inc == DW'(DEBOUNCE)) begin
                            col_n   = {col[2:0], col[3]};
                            state_n = SCAN;
                        end
                    end
                default: state_n = SCAN;
            endcase
    end

    // registered outputs and the entry action for an accepted key
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            operand   <= '0;
            op_valid  <= 1'b0;
            add       <= 1'b0;
            sub       <= 1'b0;
        end else begin
            key_valid <= fire;
            op_valid  <= fire && code == 4'd13;
            if (fire) begin
                key_code <= code;
                if (code < 4'd10) operand <= operand * 8'd10 + 8'(code);
                else if (code == 4'd10) begin
                    add <= 1'b1;
                    sub <= 1'b0;
                end else if (code == 4'd11) begin
                    add <= 1'b0;
                    sub <= 1'b1;
                end else if (code == 4'd12) begin
                    operand <= '0;
                    add     <= 1'b0;
                    sub     <= 1'b0;
                end
            end
        end
endmodule
